// File: rtl/rom_read_arbiter.sv
// Arbitrates NUM_REQ requesters onto one combinational ROM and returns each word with a valid/ready handshake.
// Define RR_ARB_EN for round-robin arbitration; otherwise the lowest requester index always wins.
module rom_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]        rsp_grant,
    output logic                      busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]  rsp_grant_q, rsp_grant_d;
    logic                gnt_any;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    cand;
    logic [NUM_REQ-1:0]  gnt_oh;
`ifdef RR_ARB_EN
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

    // Arbiter: pick the winning requester index from the current req_valid vector
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
`ifdef RR_ARB_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'(k);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
`endif
        gnt_oh = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_grant_q <= '0;
`ifdef RR_ARB_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_grant_q <= rsp_grant_d;
`ifdef RR_ARB_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_grant_d = rsp_grant_q;
`ifdef RR_ARB_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d     = FETCH;
                    rom_addr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                    rsp_grant_d = gnt_oh;
`ifdef RR_ARB_EN
                    rr_ptr_d    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
`endif
                end
            end
            FETCH: begin
                rsp_data_d = rom_data;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) ? gnt_oh : '0;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    assign rom_addr  = rom_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_grant = rsp_grant_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a 16x8 ROM model holding rom[a] = a+1.
module tb_rom_read_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_grant;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_data = {4'h0, rom_addr} + 8'h01;

    rom_read_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_grant(rsp_grant), .busy(busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_addr = '0; rsp_ready = 1'b1;
        step(); step();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rom_addr !== 4'h0 || rsp_data !== 8'h00 ||
            rsp_grant !== 4'h0 || req_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset_state got busy=%b vld=%b addr=%h data=%h grant=%b rdy=%b required all zero",
                     busy, rsp_valid, rom_addr, rsp_data, rsp_grant, req_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        req_valid = 4'b0001; req_addr = 16'h0003; rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_req_ready got=%b required=0001", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (rom_addr !== 4'h3 || busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL single_fetch got addr=%h busy=%b vld=%b rdy=%b required 3/1/0/0000",
                     rom_addr, busy, rsp_valid, req_ready);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h04 || rsp_grant !== 4'b0001) begin
            failures++;
            $display("FAIL single_resp got vld=%b data=%h grant=%b required 1/04/0001",
                     rsp_valid, rsp_data, rsp_grant);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'h3) begin
            failures++;
            $display("FAIL single_back_idle got vld=%b busy=%b addr=%h required 0/0/3",
                     rsp_valid, busy, rom_addr);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0100; req_addr = 16'h0700; rsp_ready = 1'b0;
        step();
        req_valid = '0;
        step();
        req_valid = 4'b0001; req_addr = 16'h0702;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h08 || rsp_grant !== 4'b0100 ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d got vld=%b data=%h grant=%b rdy=%b busy=%b required 1/08/0100/0000/1",
                         i, rsp_valid, rsp_data, rsp_grant, req_ready, busy);
            end
            step();
        end
        req_valid = '0; rsp_ready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release got vld=%b busy=%b required 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_all_active();
        int exp_g[5];
`ifdef RR_ARB_EN
        exp_g = '{0, 1, 2, 3, 0};
`else
        exp_g = '{0, 0, 0, 0, 0};
`endif
        pulse_reset();
        req_valid = 4'b1111; req_addr = 16'hCDEF; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] eg;
            logic [7:0] ed;
            eg = 4'b0001 << exp_g[i];
            ed = 8'(16 - exp_g[i]);
            #1;
            checks++;
            if (req_ready !== eg) begin
                failures++; $display("FAIL all_active_ready[%0d] got=%b required=%b", i, req_ready, eg);
            end
            step(); step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_grant !== eg || rsp_data !== ed) begin
                failures++;
                $display("FAIL all_active_resp[%0d] got vld=%b grant=%b data=%h required 1/%b/%h",
                         i, rsp_valid, rsp_grant, rsp_data, eg, ed);
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        int exp_g[2];
`ifdef RR_ARB_EN
        exp_g = '{3, 0};
`else
        exp_g = '{0, 0};
`endif
        pulse_reset();
        req_valid = 4'b0100; req_addr = 16'h0200; rsp_ready = 1'b1;
        step();
        req_valid = '0;
        step(); step();
        req_valid = 4'b1001; req_addr = 16'h500F;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] eg;
            logic [7:0] ed;
            eg = 4'b0001 << exp_g[i];
            ed = (exp_g[i] == 3) ? 8'h06 : 8'h10;
            #1;
            checks++;
            if (req_ready !== eg) begin
                failures++; $display("FAIL wrap_ready[%0d] got=%b required=%b", i, req_ready, eg);
            end
            step(); step();
            checks++;
            if (rsp_grant !== eg || rsp_data !== ed) begin
                failures++;
                $display("FAIL wrap_resp[%0d] got grant=%b data=%h required %b/%h", i, rsp_grant, rsp_data, eg, ed);
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_reset_midop();
        // Reset while in FETCH; requester 1 was in flight
        req_valid = 4'b0010; req_addr = 16'h0090; rsp_ready = 1'b1;
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_grant !== 4'h0 || rom_addr !== 4'h0 || rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_in_fetch got busy=%b vld=%b grant=%b addr=%h data=%h required all zero",
                     busy, rsp_valid, rsp_grant, rom_addr, rsp_data);
        end
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL reset_ptr_cleared got=%b required=0010", req_ready);
        end
        req_valid = '0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_no_reissue got busy=%b required=0", busy);
        end
        // Reset while in RESP under backpressure
        req_valid = 4'b0100; req_addr = 16'h0900; rsp_ready = 1'b0;
        step();
        req_valid = '0;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h0A) begin
            failures++; $display("FAIL reset_resp_setup got vld=%b data=%h required 1/0A", rsp_valid, rsp_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_grant !== 4'h0 || rom_addr !== 4'h0 || rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_in_resp got busy=%b vld=%b grant=%b addr=%h data=%h required all zero",
                     busy, rsp_valid, rsp_grant, rom_addr, rsp_data);
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_idle_hold();
        req_valid = 4'b1000; req_addr = 16'hA000; rsp_ready = 1'b1;
        step();
        req_valid = '0;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (req_ready !== 4'b0000 || busy !== 1'b0 || rom_addr !== 4'hA) begin
                failures++;
                $display("FAIL idle_hold cyc=%0d got rdy=%b busy=%b addr=%h required 0000/0/A",
                         i, req_ready, busy, rom_addr);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_backpressure();
        test_all_active();
        test_wrap();
        test_reset_midop();
        test_idle_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
